// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- WIDTH-bit add/subtract built from one reused 4-bit
// ripple-carry slice, one nibble per clock, behind a start/done handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   : sub selects A-B (a + ~b + 1)
//   undefined : sub is ignored and treated as 0; the port remains present
//
// Ports
//   Clk       rising-edge clock
//   Reset_n   asynchronous active-low reset
//   start     request, sampled only in IDLE
//   sub       0 = A+B, 1 = A-B, sampled with start
//   A, B      operands, sampled with start
//   busy      high while nibbles are being processed
//   done      one-cycle pulse; S/cout/overflow are valid from here on
//   S         result register (nibbles update progressively during RUN)
//   cout      carry out of the MSB (subtract: 1 = no borrow)
//   overflow  two's-complement signed overflow

module serial_adder_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [3:0]       a_nib, b_nib, sum_nib;
    logic             slice_cout;
    logic             last;
    logic             sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    // Port kept for pin compatibility; subtraction is compiled out.
    assign sub_eff = sub & 1'b0;
`endif

    assign last  = (idx == IDX_W'(NIBBLES - 1));
    assign a_nib = a_q[{idx, 2'b00} +: 4];
    assign b_nib = b_q[{idx, 2'b00} +: 4];

    serial_adder_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (sum_nib),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, per-nibble result write, final flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            S        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        // Subtract as a + ~b + 1: invert b here, +1 enters as carry.
                        b_q   <= B ^ {WIDTH{sub_eff}};
                        carry <= sub_eff;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    S[{idx, 2'b00} +: 4] <= sum_nib;
                    carry                <= slice_cout;
                    if (last) begin
                        cout     <= slice_cout;
                        // b_q is already inverted for subtract, so the add rule applies.
                        overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (sum_nib[3] != a_q[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] S;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .S        (S),
        .cout     (cout),
        .overflow (overflow)
    );

    // Reference: integer arithmetic on the operands. Returns {ovf, cout, S}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic s);
        logic signed [63:0] sa, sb, r, ua, ub, ur, smax, smin;
        logic               se;
        logic [WIDTH+1:0]   res;
`ifdef SERIAL_ADDER_SUB_EN
        se = s;
`else
        se = 1'b0 & s;
`endif
        sa   = 64'($signed(a));
        sb   = 64'($signed(b));
        ua   = 64'(a);
        ub   = 64'(b);
        smax = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (WIDTH - 1));
        if (se) begin
            r  = sa - sb;
            ur = ua - ub + (64'sd1 <<< WIDTH); // bit WIDTH set iff no borrow
        end else begin
            r  = sa + sb;
            ur = ua + ub;
        end
        res[WIDTH-1:0] = ur[WIDTH-1:0];
        res[WIDTH]     = ur[WIDTH];
        res[WIDTH+1]   = (r > smax) || (r < smin);
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One handshake from IDLE, operands scrambled right after acceptance.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int n;
        int bcnt;
        bit seen;
        @(negedge Clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        sub = 1'($urandom);
        bcnt = busy ? 1 : 0;
        n = 0;
        seen = 1'b0;
        while (n < 12 && !seen) begin
            @(posedge Clk); #1;
            n++;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
        chk({tag, "/latency"}, 32'(n), 32'(NIB));
        chk({tag, "/busy_cycles"}, 32'(bcnt), 32'(NIB));
        chk({tag, "/S"}, 32'(S), 32'(es));
        chk({tag, "/cout"}, 32'(cout), 32'(ec));
        chk({tag, "/overflow"}, 32'(overflow), 32'(eo));
        @(posedge Clk); #1;
        chk({tag, "/done_width"}, 32'(done), 32'd0);
        chk({tag, "/S_hold"}, 32'(S), 32'(es));
    endtask

    initial begin
        logic [WIDTH+1:0] m;
        logic [WIDTH+1:0] expq[$];
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int  last_acc, n_acc, n_done;
        bit  prev_busy, prev_done;

        // Reset state
        #2;
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/S", 32'(S), 32'd0);
        chk("rst/cout", 32'(cout), 32'd0);
        chk("rst/overflow", 32'(overflow), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Reset mid-RUN after E2
        @(negedge Clk);
        A = 16'hFFFF; B = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        @(posedge Clk);
        @(posedge Clk); #1;
        chk("midrst/busy_before", 32'(busy), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/done", 32'(done), 32'd0);
        chk("midrst/S", 32'(S), 32'h0000);
        chk("midrst/cout", 32'(cout), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            chk("midrst/no_done", 32'(done), 32'd0);
        end

        // Directed adds
        do_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        do_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`else
        do_op("subdis_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif

        // Random single operations
        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            if (i % 4 == 0) rb = ra;                  // a == b edge for sub
            if (i % 4 == 1) ra = {1'b0, {(WIDTH-1){1'b1}}};
            m = model(ra, rb, rs);
            do_op("rand", ra, rb, rs, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);
        end

        // start held high: re-acceptance every NIB+2 edges, operands changing every cycle
        @(negedge Clk);
        A = WIDTH'($urandom); B = WIDTH'($urandom); sub = 1'($urandom);
        start = 1'b1;
        last_acc = -1; n_acc = 0; n_done = 0;
        prev_busy = 1'b0; prev_done = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge Clk); #1;
            if (busy && !prev_busy) begin
                expq.push_back(model(A, B, sub));
                if (last_acc >= 0) chk("held/spacing", 32'(cyc - last_acc), 32'(NIB + 2));
                last_acc = cyc;
                n_acc++;
            end
            if (done) begin
                n_done++;
                chk("held/done_width", 32'(prev_done), 32'd0);
                if (expq.size() > 0) begin
                    m = expq.pop_front();
                    chk("held/S", 32'(S), 32'(m[WIDTH-1:0]));
                    chk("held/cout", 32'(cout), 32'(m[WIDTH]));
                    chk("held/overflow", 32'(overflow), 32'(m[WIDTH+1]));
                end else begin
                    chk("held/done_without_start", 32'd1, 32'd0);
                end
            end
            prev_busy = busy;
            prev_done = done;
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
            sub = 1'($urandom);
        end
        chk("held/accept_count", 32'(n_acc), 32'd5);
        chk("held/done_count", 32'(n_done), 32'd5);
        start = 1'b0;
        repeat (8) @(posedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencer that reuses one 4-bit ripple-carry adder slice to perform a WIDTH-bit add or subtract, one nibble per clock, with a start/done handshake. It sits between the lab's switch/register front end and the 4-bit adder datapath, trading latency for area: one slice instance plus a carry flop replaces a full-width adder. Operands are captured at start, and the result is held until the next accepted start.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and ≥ 8. NIBBLES = WIDTH/4.
- Clk  input  1  rising-edge clock; the only clock.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE; S/cout/overflow valid.
- S  output  WIDTH  result register.
- cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.

## Operation
- Reset (async, Reset_n=0): state=IDLE, idx=0, carry=0; S=0, cout=0, overflow=0, busy=0, done=0. Takes effect immediately, including mid-RUN; the operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, latch a=A, b=B^{WIDTH{sub}}, carry=sub, idx=0, and go to RUN. Otherwise stay in IDLE.
- RUN, each edge:
  - Slice inputs are a[4·idx+3:4·idx], b[4·idx+3:4·idx], and carry.
  - S[4·idx+3:4·idx] <= slice sum; carry <= slice cout; idx <= idx+1.
  - When idx==NIBBLES−1: cout <= slice cout, overflow <= (a[W−1]==b[W−1]) && (sum MSB != a[W−1]), state <= DONE.
- DONE: done=1 for exactly one cycle; unconditional transition to IDLE.
- start in RUN or DONE is ignored, with no queuing. A held-high start is re-accepted at the first IDLE edge.
- S nibbles update progressively during RUN. S is only guaranteed valid while done=1 and afterwards, until the next accepted start.
- Arithmetic is modulo 2^WIDTH. Subtraction uses a + ~b + 1, with the +1 supplied as the initial carry.

## Timing
- Let E0 be the edge that accepts start. Edges E1…E(NIBBLES) run the nibbles, with nibble k written at E(k+1). The state enters DONE after edge E(NIBBLES).
- done, final S, cout and overflow are visible in the cycle after E(NIBBLES). For WIDTH=16 that is 4 edges after acceptance.
- busy is high from after E0 through E(NIBBLES); it is low in DONE and IDLE.
- Minimum start-to-start spacing is NIBBLES+2 edges (6 for WIDTH=16).
- idx wraps to 0 only through the IDLE latch; it never exceeds NIBBLES−1 in RUN.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub operates as described.
- SERIAL_ADDER_SUB_EN undefined:
  - sub is ignored and treated as 0 (b=B, initial carry=0).
  - The port remains present.
  - overflow is still computed for add.

## Test plan
- Reset mid-RUN: pull Reset_n low after E2 of a 0xFFFF+0x0001 add. Expect busy=0, done=0, S=0x0000, cout=0 immediately, with no done pulse afterwards.
- 0x1234+0x0FFF, sub=0: expect done exactly 4 edges after acceptance, S=0x2233, cout=0, overflow=0, busy high for 4 cycles.
- 0xFFFF+0x0001: expect S=0x0000, cout=1, overflow=0. Then 0x7FFF+0x0001: expect S=0x8000, cout=0, overflow=1.
- With SERIAL_ADDER_SUB_EN:
  - 0x0005−0x0007: expect S=0xFFFE, cout=0, overflow=0.
  - 0x8000−0x0001: expect S=0x7FFF, cout=1, overflow=1.
- With SERIAL_ADDER_SUB_EN undefined: 0x0005 with sub=1, B=0x0007: expect S=0x000C.
- start held high continuously: expect acceptances every 6 edges, done pulses exactly 1 cycle wide, and A/B changes during RUN not affecting S.
